// File: rtl/bus_arbiter_8.sv
// Round-robin owner of the 8-source result bus: drives the mux select and grants bounded bursts.
// Grant and Sel follow Req by one edge; each beat reaches DataOut one cycle later; handover needs no idle cycle.
module bus_arbiter_8 #(
    parameter int W         = 16,
    parameter int MAX_BURST = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [7:0]   Req,
    input  logic [W-1:0] BusIn,
    output logic [2:0]   Sel,
    output logic [7:0]   Grant,
    output logic         Busy,
    output logic [W-1:0] DataOut,
    output logic         DataValid,
    output logic [2:0]   DataSrc
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t         state_q, state_d;
    logic [2:0]     owner_q, owner_d;
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic [2:0]     last_owner_q, last_owner_d;
    logic [7:0]     grant_q, grant_d;
    logic [W-1:0]   data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic [2:0]     data_src_q, data_src_d;

    logic [2:0]     search_ptr;
    logic [2:0]     winner;
    logic           any_req;
    logic           beat;
    logic           last_beat;

    // The pointer itself is visited last, so a lone requester can still win again.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        rr_pick = ptr;
        for (int i = 8; i >= 1; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign search_ptr = (state_q == S_GRANT) ? owner_q : last_owner_q;
    assign winner     = rr_pick(Req, search_ptr);
    assign any_req    = |Req;
    assign beat       = (state_q == S_GRANT) && Req[owner_q];
    assign last_beat  = (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BURST));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        data_src_d   = data_src_q;

        case (state_q)
            S_IDLE: begin
                grant_d = 8'h00;
                if (any_req) begin
                    state_d    = S_GRANT;
                    owner_d    = winner;
                    grant_d    = 8'h01 << winner;
                    beat_cnt_d = 8'd0;
                end
            end
            S_GRANT: begin
                if (beat) begin
                    data_out_d   = BusIn;
                    data_src_d   = owner_q;
                    data_valid_d = 1'b1;
                    beat_cnt_d   = beat_cnt_q + 8'd1;
                end
                if (!beat || last_beat) begin
                    last_owner_d = owner_q;
                    beat_cnt_d   = 8'd0;
                    if (any_req) begin
                        owner_d = winner;
                        grant_d = 8'h01 << winner;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 8'h00;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 3'd0;
            beat_cnt_q   <= 8'd0;
            last_owner_q <= 3'd7;
            grant_q      <= 8'h00;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            data_src_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            data_src_q   <= data_src_d;
        end
    end

    assign Sel       = owner_q;
    assign Grant     = grant_q;
    assign Busy      = (state_q == S_GRANT);
    assign DataOut   = data_out_q;
    assign DataValid = data_valid_q;
    assign DataSrc   = data_src_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed bench for bus_arbiter_8: vector table plus async-reset and full-rotation sequences.
module tb_bus_arbiter_8;

    logic        Clk;
    logic        Reset_n;
    logic [7:0]  Req;
    logic [15:0] BusIn;
    logic [2:0]  Sel;
    logic [7:0]  Grant;
    logic        Busy;
    logic [15:0] DataOut;
    logic        DataValid;
    logic [2:0]  DataSrc;

    logic [15:0] bus_drv;
    logic        use_mux;

    int n_vec;
    int n_err;

    // In mux mode the bench models the bus mux whose input k carries value k.
    assign BusIn = use_mux ? {13'b0, Sel} : bus_drv;

    bus_arbiter_8 #(.W(16), .MAX_BURST(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Req       (Req),
        .BusIn     (BusIn),
        .Sel       (Sel),
        .Grant     (Grant),
        .Busy      (Busy),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .DataSrc   (DataSrc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n;
        logic [7:0]  req;
        logic [15:0] bus;
        logic [7:0]  grant;
        logic [2:0]  sel;
        logic        busy;
        logic        dv;
        logic [15:0] dout;
        logic [2:0]  dsrc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[18];
        logic [7:0]  exp_g;
        logic [2:0]  o;
        logic [2:0]  nx;

        n_vec   = 0;
        n_err   = 0;
        Reset_n = 1'b0;
        Req     = 8'h00;
        bus_drv = 16'h0000;
        use_mux = 1'b0;

        //          rst  req    bus       grant  sel  busy dv  dout      dsrc
        tbl[0]  = '{1'b0, 8'hFF, 16'h0000, 8'h00, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0};
        tbl[1]  = '{1'b1, 8'h04, 16'h0002, 8'h04, 3'd2, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[2]  = '{1'b1, 8'h04, 16'h0002, 8'h04, 3'd2, 1'b1, 1'b1, 16'h0002, 3'd2};
        tbl[3]  = '{1'b1, 8'h04, 16'h0002, 8'h04, 3'd2, 1'b1, 1'b1, 16'h0002, 3'd2};
        tbl[4]  = '{1'b1, 8'h04, 16'h0002, 8'h04, 3'd2, 1'b1, 1'b1, 16'h0002, 3'd2};
        tbl[5]  = '{1'b1, 8'h04, 16'h0002, 8'h04, 3'd2, 1'b1, 1'b1, 16'h0002, 3'd2};
        tbl[6]  = '{1'b1, 8'h04, 16'h0002, 8'h04, 3'd2, 1'b1, 1'b1, 16'h0002, 3'd2};
        tbl[7]  = '{1'b1, 8'h08, 16'h0033, 8'h08, 3'd3, 1'b1, 1'b0, 16'h0002, 3'd2};
        tbl[8]  = '{1'b1, 8'h28, 16'h0033, 8'h08, 3'd3, 1'b1, 1'b1, 16'h0033, 3'd3};
        tbl[9]  = '{1'b1, 8'h28, 16'h0034, 8'h08, 3'd3, 1'b1, 1'b1, 16'h0034, 3'd3};
        tbl[10] = '{1'b1, 8'h20, 16'h0035, 8'h20, 3'd5, 1'b1, 1'b0, 16'h0034, 3'd3};
        tbl[11] = '{1'b1, 8'h20, 16'h0055, 8'h20, 3'd5, 1'b1, 1'b1, 16'h0055, 3'd5};
        tbl[12] = '{1'b1, 8'h40, 16'h0055, 8'h40, 3'd6, 1'b1, 1'b0, 16'h0055, 3'd5};
        tbl[13] = '{1'b1, 8'h00, 16'h0066, 8'h00, 3'd6, 1'b0, 1'b0, 16'h0055, 3'd5};
        tbl[14] = '{1'b1, 8'h41, 16'h0000, 8'h01, 3'd0, 1'b1, 1'b0, 16'h0055, 3'd5};
        tbl[15] = '{1'b1, 8'h10, 16'h0044, 8'h10, 3'd4, 1'b1, 1'b0, 16'h0055, 3'd5};
        tbl[16] = '{1'b1, 8'h10, 16'h0044, 8'h10, 3'd4, 1'b1, 1'b1, 16'h0044, 3'd4};
        tbl[17] = '{1'b1, 8'h10, 16'h0045, 8'h10, 3'd4, 1'b1, 1'b1, 16'h0045, 3'd4};

        for (int v = 0; v < 18; v++) begin
            @(negedge Clk);
            Reset_n = tbl[v].rst_n;
            Req     = tbl[v].req;
            bus_drv = tbl[v].bus;
            @(posedge Clk);
            #2;
            chk($sformatf("v%0d Grant", v),     32'(Grant),     32'(tbl[v].grant));
            chk($sformatf("v%0d Sel", v),       32'(Sel),       32'(tbl[v].sel));
            chk($sformatf("v%0d Busy", v),      32'(Busy),      32'(tbl[v].busy));
            chk($sformatf("v%0d DataValid", v), 32'(DataValid), 32'(tbl[v].dv));
            chk($sformatf("v%0d DataOut", v),   32'(DataOut),   32'(tbl[v].dout));
            chk($sformatf("v%0d DataSrc", v),   32'(DataSrc),   32'(tbl[v].dsrc));
        end

        // Asynchronous reset in the middle of owner 4's burst.
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst Grant",     32'(Grant),     32'h00);
        chk("midrst Sel",       32'(Sel),       32'h0);
        chk("midrst Busy",      32'(Busy),      32'h0);
        chk("midrst DataValid", 32'(DataValid), 32'h0);
        chk("midrst DataOut",   32'(DataOut),   32'h0000);
        chk("midrst DataSrc",   32'(DataSrc),   32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Req     = 8'h10;
        @(posedge Clk);
        #2;
        chk("postrst Grant", 32'(Grant), 32'h10);
        chk("postrst Sel",   32'(Sel),   32'h4);

        // Two full rotations with all sources requesting and the mux fed back.
        @(negedge Clk);
        Reset_n = 1'b0;
        Req     = 8'hFF;
        use_mux = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #2;
        chk("rot start Grant",     32'(Grant),     32'h01);
        chk("rot start Sel",       32'(Sel),       32'h0);
        chk("rot start DataValid", 32'(DataValid), 32'h0);
        for (int k = 0; k < 64; k++) begin
            @(posedge Clk);
            #2;
            o     = 3'((k / 4) % 8);
            nx    = 3'(((k + 1) / 4) % 8);
            exp_g = 8'h01 << nx;
            chk($sformatf("rot%0d Grant", k),     32'(Grant),        32'(exp_g));
            chk($sformatf("rot%0d DataValid", k), 32'(DataValid),    32'h1);
            chk($sformatf("rot%0d DataOut", k),   32'(DataOut),      32'(o));
            chk($sformatf("rot%0d DataSrc", k),   32'(DataSrc),      32'(o));
            chk($sformatf("rot%0d SrcTag", k),    32'(DataSrc),      32'(DataOut[2:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
